// File: rtl/uart_rx_pkg.sv
// Shared UART constants: FSM state encodings, frame-format defaults and data-width helpers.
// Imported by both the receiver and the transmitter.
package uart_rx_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_DBIT_DEF    = 8;
    localparam int UART_SB_TICK_DEF = 16;
    localparam int UART_OVERSAMPLE  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // Keeps the low dbit bits of a byte so frames narrower than 8 bits read zero above DBIT-1.
    function automatic logic [UART_DATA_W-1:0] dbit_mask(input int dbit);
        logic [UART_DATA_W:0] one_hot;
        one_hot = (UART_DATA_W+1)'(1) << dbit;
        return one_hot[UART_DATA_W-1:0] - UART_DATA_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, oversample tick and received-frame outputs of the UART receiver.
// master drives the line and tick; slave is the receiver producing the frame pulses.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                   rx;
    logic                   s_tick;
    logic                   rx_done_tick;
    logic [UART_DATA_W-1:0] dout;
    logic                   frame_err;

    modport master (
        output rx,
        output s_tick,
        input  rx_done_tick,
        input  dout,
        input  frame_err
    );

    modport slave (
        input  rx,
        input  s_tick,
        output rx_done_tick,
        output dout,
        output frame_err
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input; latency 2 clk, reset value selectable.
// No backpressure: a plain level path, re-usable for any slow asynchronous control input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, mid-bit sampling; frame pulse at the stop-phase end (2 clk sync + frame time).
// No backpressure: rx_done_tick/frame_err are single-cycle pulses, dout holds until the next frame's first data shift.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT    = UART_DBIT_DEF,
    parameter int SB_TICK = UART_SB_TICK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.slave   bus
);

    localparam logic [4:0] S_MID  = 5'(UART_OVERSAMPLE/2 - 1);
    localparam logic [4:0] S_BIT  = 5'(UART_OVERSAMPLE - 1);
    localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);
    localparam logic [UART_DATA_W-1:0] DOUT_MASK = dbit_mask(DBIT);

    uart_state_t            state, state_n;
    logic [4:0]             s_cnt, s_cnt_n;
    logic [2:0]             n_cnt, n_cnt_n;
    logic [UART_DATA_W-1:0] b_reg, b_reg_n;
    logic                   rx_s;
    logic                   stop_exit;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            b_reg <= '0;
        end else begin
            state <= state_n;
            s_cnt <= s_cnt_n;
            n_cnt <= n_cnt_n;
            b_reg <= b_reg_n;
        end
    end

    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        n_cnt_n   = n_cnt;
        b_reg_n   = b_reg;
        stop_exit = 1'b0;

        unique case (state)
            // Start detection does not wait for a tick, so a start edge right after STOP is not lost.
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end

            START: begin
                if (bus.s_tick) begin
                    if (s_cnt == S_MID) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 5'd1;
                    end
                end
            end

            DATA: begin
                if (bus.s_tick) begin
                    if (s_cnt == S_BIT) begin
                        s_cnt_n          = '0;
                        b_reg_n          = {1'b0, b_reg[UART_DATA_W-1:1]};
                        b_reg_n[DBIT-1]  = rx_s;
                        if (n_cnt == N_LAST) begin
                            state_n = STOP;
                        end else begin
                            n_cnt_n = n_cnt + 3'd1;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 5'd1;
                    end
                end
            end

            STOP: begin
                if (bus.s_tick) begin
                    if (s_cnt == S_STOP) begin
                        state_n   = IDLE;
                        stop_exit = 1'b1;
                    end else begin
                        s_cnt_n = s_cnt + 5'd1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // A bad stop bit still delivers the byte; the consumer decides what to do with frame_err.
    assign bus.rx_done_tick = stop_exit;
    assign bus.frame_err    = stop_exit & ~rx_s;
    assign bus.dout         = b_reg & DOUT_MASK;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (8N1 and 7 data bits / 2 stop bits) checked against a frame-level model.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int LAT_A = 8 + 16*8 + 16;
    localparam int LAT_B = 8 + 16*7 + 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if ifa ();
    uart_rx_if ifb ();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    uart_rx #(.DBIT(7), .SB_TICK(32)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         t0;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int n_chk = 0;
    int n_pass = 0;
    int tick_cnt = 0;
    int tcnt = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    logic [7:0] fb_data;
    logic       fb_flag;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Oversample tick: one clk in four, driven just after the rising edge.
    initial begin
        ifa.s_tick = 1'b0;
        ifb.s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            ifa.s_tick = (tcnt == 0);
            ifb.s_tick = (tcnt == 0);
        end
    end

    always @(posedge clk) if (ifa.s_tick) tick_cnt <= tick_cnt + 1;

    // Downstream flag buffer fed by the 8-bit receiver.
    always @(posedge clk) begin
        if (reset) begin
            fb_data <= 8'h00;
            fb_flag <= 1'b0;
        end else if (ifa.rx_done_tick) begin
            fb_data <= ifa.dout;
            fb_flag <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!reset && ifa.rx_done_tick) done_cnt_a <= done_cnt_a + 1;
        if (!reset && ifb.rx_done_tick) done_cnt_b <= done_cnt_b + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (ifa.rx_done_tick) begin
                if (qa.size() == 0) check("a_unexpected_tick", 1, 0);
                else begin
                    ea = qa.pop_front();
                    check("a_dout", int'(ifa.dout), int'(ea.data));
                    check("a_frame_err", int'(ifa.frame_err), int'(ea.ferr));
                    check("a_latency_ticks", tick_cnt - ea.t0 + 1, LAT_A);
                end
            end else begin
                check("a_ferr_without_tick", int'(ifa.frame_err), 0);
            end
            if (ifb.rx_done_tick) begin
                if (qb.size() == 0) check("b_unexpected_tick", 1, 0);
                else begin
                    eb = qb.pop_front();
                    check("b_dout", int'(ifb.dout), int'(eb.data));
                    check("b_frame_err", int'(ifb.frame_err), int'(eb.ferr));
                    check("b_latency_ticks", tick_cnt - eb.t0 + 1, LAT_B);
                end
            end else begin
                check("b_ferr_without_tick", int'(ifb.frame_err), 0);
            end
            check("b_dout_bit7", int'(ifb.dout[7]), 0);
        end
    end

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (ifa.s_tick) k++;
        end
        #2;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) ifa.rx = v;
        else ifb.rx = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                              input logic stop_val, input int stop_ticks);
        exp_t e;
        logic [8:0] m;
        m = 9'd1 << nbits;
        e.data = data & (m[7:0] - 8'd1);
        e.ferr = ~stop_val;
        e.t0   = tick_cnt;
        set_rx(which, 1'b0);
        if (which == 0) qa.push_back(e);
        else qb.push_back(e);
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, data[i]);
            wait_ticks(16);
        end
        set_rx(which, stop_val);
        wait_ticks(stop_ticks);
        set_rx(which, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() + qb.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending_frames", qa.size() + qb.size(), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.rx = 1'b1;
        ifb.rx = 1'b1;
        reset  = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_a_done", int'(ifa.rx_done_tick), 0);
        check("reset_a_ferr", int'(ifa.frame_err), 0);
        check("reset_a_dout", int'(ifa.dout), 0);
        check("reset_b_done", int'(ifb.rx_done_tick), 0);
        check("reset_b_dout", int'(ifb.dout), 0);

        // 0xA5, 8N1
        wait_ticks(2);
        send_frame(0, 8'hA5, 8, 1'b1, 16);
        drain();
        check("a5_flag_buf_data", int'(fb_data), 8'hA5);

        // Start glitch of 4 ticks: rejected at the mid-start sample
        set_rx(0, 1'b0);
        wait_ticks(4);
        set_rx(0, 1'b1);
        wait_ticks(24);
        check("glitch_done_count", done_cnt_a, 1);

        // 0x3C with a low stop bit
        send_frame(0, 8'h3C, 8, 1'b0, 12);
        wait_ticks(16);
        drain();
        check("3c_flag_buf_data", int'(fb_data), 8'h3C);

        // 0xFF aborted by reset during data bit 4, then 0x55
        set_rx(0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            set_rx(0, 1'b1);
            wait_ticks(16);
        end
        set_rx(0, 1'b1);
        wait_ticks(8);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("abort_dout_cleared", int'(ifa.dout), 0);
        check("abort_no_tick", int'(ifa.rx_done_tick), 0);
        wait_ticks(40);
        check("abort_done_count", done_cnt_a, 2);
        send_frame(0, 8'h55, 8, 1'b1, 16);
        drain();
        check("after_abort_flag_buf_data", int'(fb_data), 8'h55);

        // 0x00 then 0xFF back to back
        send_frame(0, 8'h00, 8, 1'b1, 16);
        send_frame(0, 8'hFF, 8, 1'b1, 16);
        drain();
        check("b2b_flag_buf_data", int'(fb_data), 8'hFF);
        check("b2b_flag_buf_flag", int'(fb_flag), 1);
        check("b2b_done_count", done_cnt_a, 5);

        // 7 data bits, 2 stop bits
        wait_ticks(4);
        send_frame(1, 8'h7F, 7, 1'b1, 32);
        drain();
        check("b_done_count", done_cnt_b, 1);
        check("b_dout_hold", int'(ifb.dout), 8'h7F);

        wait_ticks(8);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
